// File: rtl/debug_override_ctrl.sv
// Debug override controller: serial command frames load a shadow config, APPLY copies it
// atomically to the mux controls, CAPT shifts captured obs back out. Option: DBG_OVR_PARITY_EN.
module debug_override_ctrl #(
  parameter int NUM_SEL    = 10,
  parameter int WIDTH      = 3,
  parameter int OBS_W      = 9,
  parameter int SETTLE_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sdi,
  input  logic                     sdi_vld,
  input  logic [OBS_W-1:0]         obs,
  output logic [NUM_SEL-1:0]       mux_sel,
  output logic [NUM_SEL*WIDTH-1:0] mux_data,
  output logic                     sdo,
  output logic                     sdo_vld,
  output logic                     busy,
  output logic                     apply_done,
  output logic                     err
);

  localparam int CFG_LEN = NUM_SEL * (1 + WIDTH);
`ifdef DBG_OVR_PARITY_EN
  localparam int LOAD_BITS = CFG_LEN + 1;
`else
  localparam int LOAD_BITS = CFG_LEN;
`endif
  localparam int BCW = $clog2(LOAD_BITS + 1);
  localparam int SCW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int CCW = $clog2(OBS_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_OPC, S_LOAD, S_APPLY, S_SETTLE, S_CAPT
  } state_t;

  state_t             state, next_state;
  logic               op0;
  logic [BCW-1:0]     bit_cnt;
  logic [CFG_LEN-1:0] load_q;
  logic [CFG_LEN-1:0] shadow;
  logic               commit;
  logic               commit_ok;
  logic               load_last;
  logic [SCW-1:0]     settle_cnt;
  logic [OBS_W-1:0]   cap;
  logic [CCW-1:0]     cap_cnt;

  assign load_last = (state == S_LOAD) && sdi_vld && (bit_cnt == BCW'(LOAD_BITS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; sdi is only consulted in IDLE, OPC and LOAD, so bits sent while busy vanish
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (sdi_vld) next_state = S_OPC;
      S_OPC: begin
        if (sdi_vld) begin
          case ({sdi, op0})
            2'b01:   next_state = S_LOAD;
            2'b10:   next_state = S_APPLY;
            2'b11:   next_state = S_CAPT;
            default: next_state = S_IDLE;
          endcase
        end
      end
      S_LOAD:   if (load_last) next_state = S_IDLE;
      S_APPLY:  next_state = S_SETTLE;
      S_SETTLE: if (settle_cnt == '0) next_state = S_IDLE;
      S_CAPT:   if (cap_cnt == CCW'(OBS_W - 1)) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    busy       = 1'b0;
    apply_done = 1'b0;
    case (state)
      S_APPLY:  busy = 1'b1;
      S_SETTLE: begin
        busy       = 1'b1;
        apply_done = (settle_cnt == '0);
      end
      S_CAPT:   busy = 1'b1;
      default:  ;
    endcase
  end

  // Command decode and LOAD shifting; payload arrives LSB first, so shift in at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op0     <= 1'b0;
      bit_cnt <= '0;
      load_q  <= '0;
      commit  <= 1'b0;
      shadow  <= '0;
    end else begin
      if (state == S_IDLE && sdi_vld) op0 <= sdi;
      if (state != S_LOAD)  bit_cnt <= '0;
      else if (sdi_vld)     bit_cnt <= bit_cnt + 1'b1;
      if (state == S_LOAD && sdi_vld && bit_cnt < BCW'(CFG_LEN))
        load_q <= {sdi, load_q[CFG_LEN-1:1]};
      commit <= load_last && commit_ok;
      if (commit) shadow <= load_q;
    end
  end

`ifdef DBG_OVR_PARITY_EN
  logic par_acc;
  logic err_q;

  // par_acc holds the XOR of payload bits seen so far; the final bit must make it even
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state != S_LOAD) par_acc <= 1'b0;
      else if (sdi_vld)    par_acc <= par_acc ^ sdi;
      if (load_last && (par_acc ^ sdi)) err_q <= 1'b1;
    end
  end

  assign commit_ok = ~(par_acc ^ sdi);
  assign err       = err_q;
`else
  assign commit_ok = 1'b1;
  assign err       = 1'b0;
`endif

  // Live mux controls and settle timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_sel    <= '0;
      mux_data   <= '0;
      settle_cnt <= '0;
    end else begin
      if (state == S_APPLY) begin
        mux_sel    <= shadow[NUM_SEL-1:0];
        mux_data   <= shadow[CFG_LEN-1:NUM_SEL];
        settle_cnt <= SCW'(SETTLE_CYC);
      end else if (state == S_SETTLE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
    end
  end

  // Capture: obs is latched on the entry edge so sdo_vld is high for exactly the CAPT cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap     <= '0;
      cap_cnt <= '0;
      sdo     <= 1'b0;
      sdo_vld <= 1'b0;
    end else if (state == S_OPC && next_state == S_CAPT) begin
      cap     <= obs;
      cap_cnt <= '0;
      sdo     <= obs[0];
      sdo_vld <= 1'b1;
    end else if (state == S_CAPT) begin
      if (cap_cnt == CCW'(OBS_W - 1)) begin
        sdo     <= 1'b0;
        sdo_vld <= 1'b0;
      end else begin
        cap     <= cap >> 1;
        cap_cnt <= cap_cnt + 1'b1;
        sdo     <= cap[1];
      end
    end
  end

endmodule
